// File: rtl/guess_resolver.sv
// rtl/guess_resolver.sv - classifies one-hot guesses against the opponent ship map
//
// Purpose: takes each single-cell guess, rejects malformed ones, records hits and
// misses, holds the per-shot result for SHOW_CYCLES cycles and declares win/lose.
//
// Optional feature: define GUESS_REPEAT_REJECT_EN to reject guesses on cells that
// were already shot at (no shot consumed). Without it a repeated guess consumes a
// shot and shows its original class, without growing hits or hit_map.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   phase               0 = select (clears game state), 1 = game
//   guess_stb           one-cycle strobe qualifying sing_guess
//   sing_guess[27:0]    one-hot guessed cell
//   opp_ships[27:0]     opponent ship map
//   hit_map, miss_map   accumulated hit / miss cells
//   shots, hits         accepted shots / distinct hits
//   res_hit, res_miss   result display window after a hit / miss
//   rej                 one-cycle pulse for a rejected guess
//   busy                high in any state but IDLE
//   game_over, win      game finished / outcome

module guess_resolver #(
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int MAX_SHOTS   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phase,
    input  logic        guess_stb,
    input  logic [27:0] sing_guess,
    input  logic [27:0] opp_ships,
    output logic [27:0] hit_map,
    output logic [27:0] miss_map,
    output logic [4:0]  shots,
    output logic [4:0]  hits,
    output logic        res_hit,
    output logic        res_miss,
    output logic        rej,
    output logic        busy,
    output logic        game_over,
    output logic        win
);

    localparam int             CW         = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CW-1:0]  HOLD_LOAD  = CW'(SHOW_CYCLES - 1);
    localparam logic [4:0]     SHOT_LIMIT = 5'(MAX_SHOTS);

    typedef enum logic [1:0] {IDLE, CHECK, SHOW, DONE} state_t;

    state_t         state, state_n;
    logic [27:0]    g_q;
    logic [CW-1:0]  hold;
    logic           last_hit;

    logic g_invalid, g_reject, g_hit, new_hit, hold_zero, win_cond, loss_cond;

    // x & (x-1) clears the lowest set bit; anything left means more than one bit.
    assign g_invalid = (g_q == 28'd0) || ((g_q & (g_q - 28'd1)) != 28'd0);
`ifdef GUESS_REPEAT_REJECT_EN
    assign g_reject  = g_invalid || ((g_q & (hit_map | miss_map)) != 28'd0);
`else
    assign g_reject  = g_invalid;
`endif
    assign g_hit     = (g_q & opp_ships) != 28'd0;
    // A repeated hit shows as a hit but must not count as a new distinct hit.
    assign new_hit   = g_hit && ((g_q & hit_map) == 28'd0);
    assign hold_zero = (hold == '0);
    assign win_cond  = (hit_map == opp_ships) && (opp_ships != 28'd0);
    assign loss_cond = (shots == SHOT_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (phase && guess_stb) state_n = CHECK;
            CHECK: state_n = g_reject ? IDLE : SHOW;
            SHOW: begin
                if (hold_zero) begin
                    // Win is checked first so a final shot that sinks everything wins.
                    if (win_cond || loss_cond) state_n = DONE;
                    else                       state_n = IDLE;
                end
            end
            DONE:  state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (!phase) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q      <= '0;
            hold     <= '0;
            last_hit <= 1'b0;
            hit_map  <= '0;
            miss_map <= '0;
            shots    <= '0;
            hits     <= '0;
            rej      <= 1'b0;
            win      <= 1'b0;
        end else if (!phase) begin
            g_q      <= '0;
            hold     <= '0;
            last_hit <= 1'b0;
            hit_map  <= '0;
            miss_map <= '0;
            shots    <= '0;
            hits     <= '0;
            rej      <= 1'b0;
            win      <= 1'b0;
        end else begin
            rej <= 1'b0;
            case (state)
                IDLE: begin
                    if (guess_stb) g_q <= sing_guess;
                end
                CHECK: begin
                    if (g_reject) begin
                        rej <= 1'b1;
                    end else begin
                        shots    <= shots + 5'd1;
                        last_hit <= g_hit;
                        hold     <= HOLD_LOAD;
                        if (g_hit) begin
                            hit_map <= hit_map | g_q;
                            if (new_hit) hits <= hits + 5'd1;
                        end else begin
                            miss_map <= miss_map | g_q;
                        end
                    end
                end
                SHOW: begin
                    if (!hold_zero) hold <= hold - CW'(1);
                    else if (win_cond) win <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign game_over = (state == DONE);
    assign res_hit   = (state == SHOW) && last_hit;
    assign res_miss  = (state == SHOW) && !last_hit;

endmodule

// File: tb/tb_guess_resolver.sv
// tb/tb_guess_resolver.sv - directed self-checking bench for guess_resolver

module tb_guess_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        phase;
    logic        guess_stb;
    logic [27:0] sing_guess;
    logic [27:0] opp_ships;
    logic [27:0] hit_map, miss_map;
    logic [4:0]  shots, hits;
    logic        res_hit, res_miss, rej, busy, game_over, win;

    int n_assert = 0;
    int n_fail   = 0;

    guess_resolver #(.SHOW_CYCLES(4), .MAX_SHOTS(2)) dut (
        .clk(clk), .rst(rst), .phase(phase), .guess_stb(guess_stb),
        .sing_guess(sing_guess), .opp_ships(opp_ships),
        .hit_map(hit_map), .miss_map(miss_map), .shots(shots), .hits(hits),
        .res_hit(res_hit), .res_miss(res_miss), .rej(rej), .busy(busy),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe for one cycle; returns just after the edge that moves IDLE -> CHECK.
    task automatic guess(input logic [27:0] g);
        sing_guess = g;
        guess_stb  = 1'b1;
        step(1);
        guess_stb  = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        phase      = $urandom_range(1, 0);
        guess_stb  = $urandom_range(1, 0);
        sing_guess = 28'($urandom);
        opp_ships  = 28'($urandom);
        step(3);
        chk("reset_hit_map", 32'(hit_map), 32'h0);
        chk("reset_miss_map", 32'(miss_map), 32'h0);
        chk("reset_counters", {22'd0, shots, hits}, 32'h0);
        chk("reset_flags", {26'd0, res_hit, res_miss, rej, busy, game_over, win}, 32'h0);

        phase     = 1'b0;
        guess_stb = 1'b0;
        opp_ships = 28'h0000003;
        step(1);
        rst = 1'b1;
        step(1);
        guess(28'h1);
        chk("phase0_busy", {31'd0, busy}, 32'h0);
        step(1);
        chk("phase0_noresp", {27'd0, busy, rej, res_hit, res_miss, game_over}, 32'h0);

        // Malformed guesses
        phase = 1'b1;
        step(1);
        guess(28'h0);
        chk("inv0_busy_check", {30'd0, busy, rej}, 32'h2);
        step(1);
        chk("inv0_rej", {28'd0, rej, busy, res_hit, res_miss}, 32'h8);
        step(1);
        chk("inv0_rej_one_cycle", {31'd0, rej}, 32'h0);
        guess(28'h3);
        step(1);
        chk("inv3_rej", {28'd0, rej, busy, res_hit, res_miss}, 32'h8);
        chk("inv_shots", 32'(shots), 32'h0);
        step(1);

        // First hit, SHOW window of 4 cycles
        guess(28'h1);
        chk("hit_check_busy", {30'd0, busy, res_hit}, 32'h2);
        step(1);
        chk("hit_res", {29'd0, res_hit, res_miss, busy}, 32'h5);
        chk("hit_map1", 32'(hit_map), 32'h1);
        chk("hit_counts1", {22'd0, shots, hits}, {22'd0, 5'd1, 5'd1});
        step(3);
        chk("hit_res_held", {30'd0, res_hit, busy}, 32'h3);
        step(1);
        chk("hit_res_end", {29'd0, res_hit, busy, game_over}, 32'h0);

        // Second hit sinks all ships; it is also shot MAX_SHOTS, win must prevail
        guess(28'h2);
        step(1);
        chk("win_counts", {22'd0, shots, hits}, {22'd0, 5'd2, 5'd2});
        chk("win_map", 32'(hit_map), 32'h3);
        step(3);
        chk("win_not_yet", {31'd0, game_over}, 32'h0);
        step(1);
        chk("win_done", {28'd0, game_over, win, res_hit, busy}, 32'hD);
        guess(28'h4);
        step(3);
        chk("done_frozen_shots", 32'(shots), 32'h2);
        chk("done_frozen_flags", {28'd0, game_over, win, res_miss, rej}, 32'hC);

        // phase=0 clears everything on the next edge
        phase = 1'b0;
        step(1);
        chk("phase_clear", {17'd0, shots, hits, game_over, win, busy, hit_map[1:0]}, 32'h0);
        phase = 1'b1;
        step(1);

        // Miss, then repeat of the same cell
        guess(28'h10);
        step(1);
        chk("miss_res", {30'd0, res_miss, res_hit}, 32'h2);
        chk("miss_map", 32'(miss_map), 32'h10);
        chk("miss_counts", {22'd0, shots, hits}, {22'd0, 5'd1, 5'd0});
        step(4);
        chk("miss_end", {30'd0, busy, game_over}, 32'h0);
        guess(28'h10);
        step(1);
`ifdef GUESS_REPEAT_REJECT_EN
        chk("repeat_rej", {30'd0, rej, res_miss}, 32'h2);
        chk("repeat_shots", 32'(shots), 32'h1);
        step(1);
        chk("repeat_no_done", {30'd0, game_over, busy}, 32'h0);
`else
        chk("repeat_res_miss", {30'd0, res_miss, rej}, 32'h2);
        chk("repeat_shots", 32'(shots), 32'h2);
        step(4);
        chk("loss_done", {29'd0, game_over, win, res_miss}, 32'h4);
`endif

        // Abort mid-SHOW with phase=0
        phase = 1'b0;
        step(1);
        phase = 1'b1;
        step(1);
        guess(28'h1);
        step(2);
        chk("abort_in_show", {31'd0, res_hit}, 32'h1);
        phase = 1'b0;
        step(1);
        chk("abort_clear", {15'd0, shots, hits, busy, res_hit, hit_map[1:0], miss_map[4]}, 32'h0);
        phase = 1'b1;
        step(1);

        // Asynchronous reset while in CHECK
        guess(28'h1);
        chk("rst_in_check", {31'd0, busy}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_clear", {20'd0, busy, shots, hits, hit_map[0]}, 32'h0);
        step(1);
        rst = 1'b1;
        step(2);
        chk("rst_no_partial", {20'd0, busy, shots, hits, res_hit}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
